spi_target: RTL

- SPI mode-0 responder (target): the far end of the SPI master channels in the peripherals block.
- Lets the FPGA act as a peripheral to an external SPI host, or closes an on-board loopback for self-test.
- All SPI pins are oversampled and synchronised into the raw_clk domain.
- CPU-side interface matches the peripherals handshake style: data/strobe/busy plus rx_ready/rx_ready_clear.

---
 rtl/spi_target_pkg.sv | 21 ++
 rtl/spi_target_sync.sv | 39 +++
 rtl/spi_target.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared constants, frame state type and helpers for the SPI target.
package spi_target_pkg;

   // Index of the final bit of a word (bit_count value at completion).
   localparam logic [3:0]  SPI_W8_LAST  = 4'd7;
   localparam logic [3:0]  SPI_W16_LAST = 4'd15;

   // Word shifted out when the host clocks a word with nothing loaded.
   localparam logic [15:0] TX_IDLE_WORD = 16'h0000;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } frame_state_e;

   // First bit on the wire for a word: bit 15 in 16-bit frames, bit 7 in 8-bit frames.
   function automatic logic word_msb(input logic [15:0] word, input logic w16);
      return w16 ? word[15] : word[7];
   endfunction

endpackage

// File: rtl/spi_target_sync.sv
// spi_target_sync: STAGES-deep synchroniser plus one edge-detect flop.
// rise/fall are single raw_clk pulses, STAGES+1 cycles after the pin moves.
module spi_target_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic raw_clk,
   input  logic reset_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              prev_q;
   logic              prev_d;

   // Next values: shift the pin into the chain, remember the previous synced level.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      prev_d = sync_q[STAGES-1];
   end

   // Synchroniser and edge-detect registers; reset to the pin's idle level.
   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target, all pins oversampled in the raw_clk domain.
// Optional build macro SPI_TARGET_RX_FIFO_EN replaces the single RX register
// (overwrite on overrun) with a FIFO_DEPTH-entry RX FIFO (drop on full).
module spi_target
   import spi_target_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        raw_clk,
   input  logic        reset_n,
   input  logic        width_16,
   input  logic [15:0] tx_data,
   input  logic        tx_load,
   output logic        tx_empty,
   output logic [15:0] rx_data,
   output logic        rx_ready,
   input  logic        rx_ready_clear,
   output logic        rx_overrun,
   output logic        busy,
   input  logic        spi_clk,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe
);

   logic                   sclk_rise_s;
   logic                   sclk_fall_s;
   logic                   cs_rise_s;
   logic                   cs_fall_s;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_d;
   logic                   mosi_s;

   frame_state_e           state_q, state_d;
   logic                   frame_w16_q, frame_w16_d;
   logic [3:0]             bit_count_q, bit_count_d;
   logic [14:0]            rx_shift_q, rx_shift_d;
   logic [15:0]            tx_shift_q, tx_shift_d;
   logic [15:0]            tx_buf_q, tx_buf_d;
   logic                   tx_empty_q, tx_empty_d;
   logic                   miso_q, miso_d;
   logic                   miso_oe_q, miso_oe_d;

   logic [15:0]            rx_next_s;
   logic [15:0]            reload_word_s;
   logic [15:0]            tx_shifted_s;
   logic [3:0]             last_s;
   logic                   word_done_s;
   logic [15:0]            word_s;

   spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .raw_clk (raw_clk),
      .reset_n (reset_n),
      .din     (spi_clk),
      .rise    (sclk_rise_s),
      .fall    (sclk_fall_s)
   );

   spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .raw_clk (raw_clk),
      .reset_n (reset_n),
      .din     (spi_cs_n),
      .rise    (cs_rise_s),
      .fall    (cs_fall_s)
   );

   // MOSI chain has the same depth as the sclk chain, so it is aligned with sclk_rise_s.
   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
   end

   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Frame FSM, shift registers and TX holding register next-state logic.
   always_comb begin
      state_d       = state_q;
      frame_w16_d   = frame_w16_q;
      bit_count_d   = bit_count_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      tx_buf_d      = tx_buf_q;
      tx_empty_d    = tx_empty_q;
      miso_d        = miso_q;
      miso_oe_d     = miso_oe_q;
      word_done_s   = 1'b0;
      word_s        = 16'h0000;
      rx_next_s     = {rx_shift_q, mosi_s};
      reload_word_s = tx_empty_q ? TX_IDLE_WORD : tx_buf_q;
      tx_shifted_s  = tx_shift_q << 1'b1;
      last_s        = frame_w16_q ? SPI_W16_LAST : SPI_W8_LAST;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall_s) begin
               state_d     = ST_FRAME;
               frame_w16_d = width_16;
               bit_count_d = 4'd0;
               rx_shift_d  = 15'h0000;
               tx_shift_d  = reload_word_s;
               tx_empty_d  = 1'b1;
               miso_d      = word_msb(reload_word_s, width_16);
               miso_oe_d   = 1'b1;
            end else begin
               bit_count_d = 4'd0;
               miso_d      = 1'b0;
               miso_oe_d   = 1'b0;
            end
         end
         ST_FRAME: begin
            if (cs_rise_s) begin
               // Any partial word is simply abandoned here.
               state_d     = ST_IDLE;
               bit_count_d = 4'd0;
               miso_d      = 1'b0;
               miso_oe_d   = 1'b0;
            end else if (sclk_rise_s) begin
               rx_shift_d = rx_next_s[14:0];
               if (bit_count_q == last_s) begin
                  bit_count_d = 4'd0;
                  word_done_s = 1'b1;
                  word_s      = frame_w16_q ? rx_next_s : {8'h00, rx_next_s[7:0]};
               end else begin
                  bit_count_d = bit_count_q + 4'd1;
               end
            end else if (sclk_fall_s) begin
               if (bit_count_q == 4'd0) begin
                  // Word boundary inside a continuous frame: fetch the next TX word.
                  tx_shift_d = reload_word_s;
                  tx_empty_d = 1'b1;
                  miso_d     = word_msb(reload_word_s, frame_w16_q);
               end else begin
                  tx_shift_d = tx_shifted_s;
                  miso_d     = word_msb(tx_shifted_s, frame_w16_q);
               end
            end else begin
               state_d = ST_FRAME;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            bit_count_d = 4'd0;
            miso_d      = 1'b0;
            miso_oe_d   = 1'b0;
         end
      endcase

      // A load wins over a same-cycle consumption: the shifter took the old value above.
      if (tx_load) begin
         tx_buf_d   = tx_data;
         tx_empty_d = 1'b0;
      end else begin
         tx_buf_d = tx_buf_q;
      end
   end

   // Frame, shift and TX registers.
   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         mosi_sync_q <= '0;
         state_q     <= ST_IDLE;
         frame_w16_q <= 1'b0;
         bit_count_q <= 4'd0;
         rx_shift_q  <= 15'h0000;
         tx_shift_q  <= 16'h0000;
         tx_buf_q    <= 16'h0000;
         tx_empty_q  <= 1'b1;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
      end else begin
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         frame_w16_q <= frame_w16_d;
         bit_count_q <= bit_count_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         tx_buf_q    <= tx_buf_d;
         tx_empty_q  <= tx_empty_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
      end
   end

   assign busy        = (state_q == ST_FRAME);
   assign tx_empty    = tx_empty_q;
   assign spi_miso    = miso_q;
   assign spi_miso_oe = miso_oe_q;

`ifdef SPI_TARGET_RX_FIFO_EN
   localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [15:0]      fifo_mem_q [FIFO_DEPTH];
   logic [15:0]      fifo_mem_d [FIFO_DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
   logic             rx_overrun_q, rx_overrun_d;
   logic             fifo_empty_s;
   logic             fifo_full_s;
   logic             fifo_pop_s;
   logic             fifo_push_s;

   // FIFO status; a pop in the same cycle frees the slot a full FIFO needs.
   always_comb begin
      fifo_empty_s = (wr_ptr_q == rd_ptr_q);
      fifo_full_s  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
      fifo_pop_s   = rx_ready_clear && !fifo_empty_s;
      fifo_push_s  = word_done_s && (!fifo_full_s || fifo_pop_s);
   end

   // FIFO storage, pointers and sticky overrun next-state.
   always_comb begin
      fifo_mem_d   = fifo_mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rx_overrun_d = rx_overrun_q;
      if (fifo_push_s) begin
         fifo_mem_d[wr_ptr_q[FIFO_AW-1:0]] = word_s;
         wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (fifo_pop_s) begin
         rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (word_done_s && !fifo_push_s) begin
         rx_overrun_d = 1'b1;
      end else if (rx_ready_clear) begin
         rx_overrun_d = 1'b0;
      end else begin
         rx_overrun_d = rx_overrun_q;
      end
   end

   // FIFO registers.
   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= 16'h0000;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rx_overrun_q <= 1'b0;
      end else begin
         fifo_mem_q   <= fifo_mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   assign rx_data    = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign rx_ready   = !fifo_empty_s;
   assign rx_overrun = rx_overrun_q;
`else
   logic [15:0] rx_data_q, rx_data_d;
   logic        rx_ready_q, rx_ready_d;
   logic        rx_overrun_q, rx_overrun_d;

   // Single RX register: a new word overwrites; overrun if the old one was never acknowledged.
   always_comb begin
      rx_data_d    = rx_data_q;
      rx_ready_d   = rx_ready_q;
      rx_overrun_d = rx_overrun_q;
      if (rx_ready_clear) begin
         rx_ready_d   = 1'b0;
         rx_overrun_d = 1'b0;
      end else begin
         rx_ready_d = rx_ready_q;
      end
      if (word_done_s) begin
         rx_data_d  = word_s;
         rx_ready_d = 1'b1;
         if (rx_ready_q && !rx_ready_clear) begin
            rx_overrun_d = 1'b1;
         end else begin
            rx_data_d = word_s;
         end
      end else begin
         rx_data_d = rx_data_q;
      end
   end

   // RX result registers.
   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data_q    <= 16'h0000;
         rx_ready_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         rx_data_q    <= rx_data_d;
         rx_ready_q   <= rx_ready_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_ready   = rx_ready_q;
   assign rx_overrun = rx_overrun_q;

   // FIFO_DEPTH only sizes the RX FIFO of the other build; nothing to generate here.
   if (FIFO_DEPTH < 32'sd1) begin : g_fifo_depth_unused
   end
`endif

endmodule
